// File: rtl/nasti_sram_slave_if.sv
// NASTI (AXI4-style) channel bundle shared by a master and the slave it talks to.
// Holds the AW/W/B/AR/R payload, valid and ready signals, with master and slave views.
interface nasti_if #(
   parameter int unsigned ID_WIDTH   = 9,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned USER_WIDTH = 1
);
   logic [ID_WIDTH-1:0]     aw_id;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;
   logic                    aw_lock;
   logic [3:0]              aw_cache;
   logic [2:0]              aw_prot;
   logic [3:0]              aw_qos;
   logic [3:0]              aw_region;
   logic [USER_WIDTH-1:0]   aw_user;
   logic                    aw_valid;
   logic                    aw_ready;

   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_last;
   logic [USER_WIDTH-1:0]   w_user;
   logic                    w_valid;
   logic                    w_ready;

   logic [ID_WIDTH-1:0]     b_id;
   logic [1:0]              b_resp;
   logic [USER_WIDTH-1:0]   b_user;
   logic                    b_valid;
   logic                    b_ready;

   logic [ID_WIDTH-1:0]     ar_id;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]              ar_len;
   logic [2:0]              ar_size;
   logic [1:0]              ar_burst;
   logic                    ar_lock;
   logic [3:0]              ar_cache;
   logic [2:0]              ar_prot;
   logic [3:0]              ar_qos;
   logic [3:0]              ar_region;
   logic [USER_WIDTH-1:0]   ar_user;
   logic                    ar_valid;
   logic                    ar_ready;

   logic [ID_WIDTH-1:0]     r_id;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp;
   logic                    r_last;
   logic [USER_WIDTH-1:0]   r_user;
   logic                    r_valid;
   logic                    r_ready;

   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/nasti_sram_slave.sv
// NASTI slave backed by a word-addressed memory array; FIXED/INCR full-width bursts,
// independent write (AW/W/B) and read (AR/R) state machines, one transaction in flight each.
module nasti_sram_slave #(
   parameter int unsigned C_NASTI_ID_WIDTH   = 9,
   parameter int unsigned C_NASTI_ADDR_WIDTH = 32,
   parameter int unsigned C_NASTI_DATA_WIDTH = 64,
   parameter int unsigned C_NASTI_USER_WIDTH = 1,
   parameter int unsigned MEM_WORDS          = 1024
) (
   input logic     clk,
   input logic     rst,
   nasti_if.slave  s
);
   localparam int unsigned BW  = C_NASTI_DATA_WIDTH / 8;
   localparam int unsigned OFF = $clog2(BW);
   localparam int unsigned IW  = $clog2(MEM_WORDS);
   localparam int unsigned DW  = C_NASTI_DATA_WIDTH;
   localparam int unsigned IDW = C_NASTI_ID_WIDTH;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   function automatic logic f_unsup(input logic [1:0] burst, input logic [2:0] size);
      return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size != 3'(OFF));
   endfunction

   logic [DW-1:0] r_mem [MEM_WORDS];

   // ---------------- write channel ----------------
   w_state_t         r_wstate, w_wstate_nxt;
   logic [IDW-1:0]   r_wid;
   logic [IW-1:0]    r_widx;
   logic [7:0]       r_wlen;
   logic [7:0]       r_wcnt;
   logic             r_wincr;
   logic             r_wunsup;
   logic             r_wlast_err;
   logic             w_aw_hs;
   logic             w_w_hs;
   logic             w_wfinal;

   assign w_aw_hs  = (r_wstate == W_IDLE) && s.aw_valid;
   assign w_w_hs   = (r_wstate == W_DATA) && s.w_valid;
   assign w_wfinal = (r_wcnt == r_wlen);

   always_ff @(posedge clk) begin
      if (rst) r_wstate <= W_IDLE;
      else     r_wstate <= w_wstate_nxt;
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      case (r_wstate)
         W_IDLE:  if (s.aw_valid)            w_wstate_nxt = W_DATA;
         W_DATA:  if (s.w_valid && w_wfinal) w_wstate_nxt = W_RESP;
         W_RESP:  if (s.b_ready)             w_wstate_nxt = W_IDLE;
         default:                            w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wid       <= '0;
         r_widx      <= '0;
         r_wlen      <= '0;
         r_wcnt      <= '0;
         r_wincr     <= 1'b0;
         r_wunsup    <= 1'b0;
         r_wlast_err <= 1'b0;
      end else if (w_aw_hs) begin
         r_wid       <= s.aw_id;
         r_widx      <= s.aw_addr[OFF+IW-1:OFF];
         r_wlen      <= s.aw_len;
         r_wcnt      <= '0;
         r_wincr     <= (s.aw_burst == BURST_INCR);
         r_wunsup    <= f_unsup(s.aw_burst, s.aw_size);
         r_wlast_err <= 1'b0;
      end else if (w_w_hs) begin
         r_widx <= r_wincr ? r_widx + IW'(1) : r_widx;
         r_wcnt <= r_wcnt + 8'd1;
         if (s.w_last != w_wfinal) r_wlast_err <= 1'b1;
      end
   end

   // Byte-lane merge into the array; contents survive reset.
   always_ff @(posedge clk) begin
      if (!rst && w_w_hs && !r_wunsup) begin
         for (int unsigned b = 0; b < BW; b++) begin
            if (s.w_strb[b]) r_mem[r_widx][8*b +: 8] <= s.w_data[8*b +: 8];
         end
      end
   end

   assign s.aw_ready = (r_wstate == W_IDLE);
   assign s.w_ready  = (r_wstate == W_DATA);
   assign s.b_valid  = (r_wstate == W_RESP);
   assign s.b_id     = r_wid;
   assign s.b_resp   = (r_wunsup || r_wlast_err) ? RESP_SLVERR : RESP_OKAY;
   assign s.b_user   = '0;

   // ---------------- read channel ----------------
   r_state_t         r_rstate, w_rstate_nxt;
   logic [IDW-1:0]   r_rid;
   logic [IW-1:0]    r_ridx;
   logic [7:0]       r_rlen;
   logic [7:0]       r_rcnt;
   logic             r_rincr;
   logic             r_runsup;
   logic [DW-1:0]    r_rdata;
   logic             w_ar_hs;
   logic             w_r_hs;
   logic             w_rlast;
   logic             w_ar_unsup;
   logic [IW-1:0]    w_ar_idx;
   logic [IW-1:0]    w_ridx_nxt;

   assign w_ar_hs    = (r_rstate == R_IDLE) && s.ar_valid;
   assign w_r_hs     = (r_rstate == R_DATA) && s.r_ready;
   assign w_rlast    = (r_rstate == R_DATA) && (r_rcnt == r_rlen);
   assign w_ar_unsup = f_unsup(s.ar_burst, s.ar_size);
   assign w_ar_idx   = s.ar_addr[OFF+IW-1:OFF];
   assign w_ridx_nxt = r_rincr ? r_ridx + IW'(1) : r_ridx;

   always_ff @(posedge clk) begin
      if (rst) r_rstate <= R_IDLE;
      else     r_rstate <= w_rstate_nxt;
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (s.ar_valid)            w_rstate_nxt = R_DATA;
         R_DATA:  if (s.r_ready && w_rlast)  w_rstate_nxt = R_IDLE;
         default:                            w_rstate_nxt = R_IDLE;
      endcase
   end

   // Array is read on the load edge, so a same-edge write is not yet visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rid    <= '0;
         r_ridx   <= '0;
         r_rlen   <= '0;
         r_rcnt   <= '0;
         r_rincr  <= 1'b0;
         r_runsup <= 1'b0;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rid    <= s.ar_id;
         r_ridx   <= w_ar_idx;
         r_rlen   <= s.ar_len;
         r_rcnt   <= '0;
         r_rincr  <= (s.ar_burst == BURST_INCR);
         r_runsup <= w_ar_unsup;
         r_rdata  <= w_ar_unsup ? '0 : r_mem[w_ar_idx];
      end else if (w_r_hs && !w_rlast) begin
         r_ridx  <= w_ridx_nxt;
         r_rcnt  <= r_rcnt + 8'd1;
         r_rdata <= r_runsup ? '0 : r_mem[w_ridx_nxt];
      end
   end

   assign s.ar_ready = (r_rstate == R_IDLE);
   assign s.r_valid  = (r_rstate == R_DATA);
   assign s.r_id     = r_rid;
   assign s.r_data   = r_rdata;
   assign s.r_resp   = r_runsup ? RESP_SLVERR : RESP_OKAY;
   assign s.r_last   = w_rlast;
   assign s.r_user   = '0;

   // Sideband fields and upper address bits carry no meaning for this responder.
   logic w_unused;
   assign w_unused = ^{s.aw_addr, s.aw_lock, s.aw_cache, s.aw_prot, s.aw_qos, s.aw_region,
                       s.aw_user, s.w_user, s.ar_addr, s.ar_lock, s.ar_cache, s.ar_prot,
                       s.ar_qos, s.ar_region, s.ar_user};
endmodule

// File: tb/tb_nasti_sram_slave.sv
// Self-checking bench for nasti_sram_slave: directed cases plus random bursts,
// scored against a word-array model updated from the burst rules.
module tb_nasti_sram_slave;
   localparam int unsigned IDW = 9;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 64;
   localparam int unsigned UW  = 1;
   localparam int unsigned MW  = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nasti_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();

   nasti_sram_slave #(
      .C_NASTI_ID_WIDTH(IDW), .C_NASTI_ADDR_WIDTH(AW), .C_NASTI_DATA_WIDTH(DW),
      .C_NASTI_USER_WIDTH(UW), .MEM_WORDS(MW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s(s_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] model [MW];
   logic [63:0] bdata [256];
   logic [7:0]  bstrb [256];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      s_if.aw_id = '0; s_if.aw_addr = '0; s_if.aw_len = '0; s_if.aw_size = '0;
      s_if.aw_burst = '0; s_if.aw_lock = 1'b0; s_if.aw_cache = '0; s_if.aw_prot = '0;
      s_if.aw_qos = '0; s_if.aw_region = '0; s_if.aw_user = '0; s_if.aw_valid = 1'b0;
      s_if.w_data = '0; s_if.w_strb = '0; s_if.w_last = 1'b0; s_if.w_user = '0;
      s_if.w_valid = 1'b0; s_if.b_ready = 1'b0;
      s_if.ar_id = '0; s_if.ar_addr = '0; s_if.ar_len = '0; s_if.ar_size = '0;
      s_if.ar_burst = '0; s_if.ar_lock = 1'b0; s_if.ar_cache = '0; s_if.ar_prot = '0;
      s_if.ar_qos = '0; s_if.ar_region = '0; s_if.ar_user = '0; s_if.ar_valid = 1'b0;
      s_if.r_ready = 1'b0;
   endtask

   function automatic int unsigned word_of(input logic [31:0] addr, input int unsigned beat,
                                           input logic [1:0] burst);
      int unsigned base;
      base = addr >> 3;
      return (base + ((burst == 2'b01) ? beat : 0)) % MW;
   endfunction

   function automatic bit is_ok(input logic [1:0] burst, input logic [2:0] size);
      return ((burst == 2'b00) || (burst == 2'b01)) && (size == 3'd3);
   endfunction

   task automatic model_write(input int unsigned idx, input logic [63:0] d, input logic [7:0] st);
      for (int b = 0; b < 8; b++) if (st[b]) model[idx][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic send_aw(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
      int t;
      s_if.aw_id = id; s_if.aw_addr = addr; s_if.aw_len = len; s_if.aw_burst = burst;
      s_if.aw_size = size; s_if.aw_cache = 4'($urandom); s_if.aw_prot = 3'($urandom);
      s_if.aw_lock = 1'($urandom); s_if.aw_user = 1'($urandom); s_if.aw_valid = 1'b1;
      t = 0;
      while (!s_if.aw_ready && t < 100) begin step(); t++; end
      check("aw_ready", 64'(s_if.aw_ready), 64'd1);
      step();
      s_if.aw_valid = 1'b0;
   endtask

   // early >= 0 raises w_last on that beat instead of the final one.
   task automatic do_write(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int early,
                           input bit gaps);
      int t;
      bit ok;
      ok = is_ok(burst, size);
      send_aw(id, addr, len, burst, size);
      for (int i = 0; i <= int'(len); i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            s_if.w_valid = 1'b0;
            step();
         end
         s_if.w_data  = bdata[i];
         s_if.w_strb  = bstrb[i];
         s_if.w_last  = (early >= 0) ? (i == early) : (i == int'(len));
         s_if.w_valid = 1'b1;
         t = 0;
         while (!s_if.w_ready && t < 100) begin step(); t++; end
         check("w_ready", 64'(s_if.w_ready), 64'd1);
         step();
         if (ok) model_write(word_of(addr, i, burst), bdata[i], bstrb[i]);
      end
      s_if.w_valid = 1'b0;
      s_if.w_last  = 1'b0;
      check("b_valid_lat", 64'(s_if.b_valid), 64'd1);
      check("b_id", 64'(s_if.b_id), 64'(id));
      check("b_resp", 64'(s_if.b_resp), (ok && early < 0) ? 64'd0 : 64'd2);
      repeat ($urandom_range(0, 2)) begin
         step();
         check("b_hold", 64'(s_if.b_valid), 64'd1);
      end
      s_if.b_ready = 1'b1;
      step();
      s_if.b_ready = 1'b0;
      check("b_drop", 64'(s_if.b_valid), 64'd0);
   endtask

   // mode 0: always ready, 1: toggling, 2: random back-pressure.
   task automatic do_read(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int mode);
      int t;
      int beat;
      bit ok;
      bit rr;
      logic [63:0] exp;
      ok = is_ok(burst, size);
      s_if.ar_id = id; s_if.ar_addr = addr; s_if.ar_len = len; s_if.ar_burst = burst;
      s_if.ar_size = size; s_if.ar_qos = 4'($urandom); s_if.ar_region = 4'($urandom);
      s_if.ar_valid = 1'b1;
      t = 0;
      while (!s_if.ar_ready && t < 100) begin step(); t++; end
      check("ar_ready", 64'(s_if.ar_ready), 64'd1);
      step();
      s_if.ar_valid = 1'b0;
      check("r_valid_lat", 64'(s_if.r_valid), 64'd1);
      beat = 0;
      t = 0;
      while (beat <= int'(len) && t < 1000) begin
         case (mode)
            0:       rr = 1'b1;
            1:       rr = (t % 2 == 1);
            default: rr = 1'($urandom_range(0, 1));
         endcase
         s_if.r_ready = rr;
         exp = ok ? model[word_of(addr, beat, burst)] : 64'd0;
         check("r_valid", 64'(s_if.r_valid), 64'd1);
         check("r_data", s_if.r_data, exp);
         check("r_last", 64'(s_if.r_last), 64'(beat == int'(len)));
         check("r_id", 64'(s_if.r_id), 64'(id));
         check("r_resp", 64'(s_if.r_resp), ok ? 64'd0 : 64'd2);
         step();
         if (rr) beat++;
         t++;
      end
      s_if.r_ready = 1'b0;
      check("r_beats", 64'(beat), 64'(int'(len) + 1));
      check("r_done", 64'(s_if.r_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] old_val;
      logic [63:0] new_val;
      logic [31:0] ra;
      logic [7:0]  rl;
      logic [1:0]  rb;
      logic [2:0]  rs;
      int t;

      bus_idle();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;

      check("rst_aw_ready", 64'(s_if.aw_ready), 64'd1);
      check("rst_ar_ready", 64'(s_if.ar_ready), 64'd1);
      check("rst_w_ready", 64'(s_if.w_ready), 64'd0);
      check("rst_b_valid", 64'(s_if.b_valid), 64'd0);
      check("rst_r_valid", 64'(s_if.r_valid), 64'd0);
      check("rst_r_last", 64'(s_if.r_last), 64'd0);
      check("rst_ids", 64'({s_if.b_id, s_if.r_id}), 64'd0);
      check("rst_resps", 64'({s_if.b_resp, s_if.r_resp}), 64'd0);
      check("rst_r_data", s_if.r_data, 64'd0);

      // Fill the whole array so every later read has a known expectation.
      for (int i = 0; i < int'(MW); i++) begin
         bdata[i] = {$urandom, $urandom};
         bstrb[i] = 8'hFF;
      end
      do_write(9'h001, 32'h0, 8'(MW - 1), 2'b01, 3'd3, -1, 1'b0);

      // Single write then read.
      bdata[0] = 64'h1122334455667788; bstrb[0] = 8'hFF;
      do_write(9'h1A5, 32'h40, 8'd0, 2'b01, 3'd3, -1, 1'b0);
      do_read(9'h0C3, 32'h40, 8'd0, 2'b01, 3'd3, 0);

      // INCR len 3 with toggling r_ready.
      for (int i = 0; i < 4; i++) begin bdata[i] = {$urandom, $urandom}; bstrb[i] = 8'hFF; end
      do_write(9'h002, 32'h100, 8'd3, 2'b01, 3'd3, -1, 1'b1);
      do_read(9'h003, 32'h100, 8'd3, 2'b01, 3'd3, 1);

      // Partial strobe over an all-ones word.
      bdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; bstrb[0] = 8'hFF;
      do_write(9'h004, 32'h0, 8'd0, 2'b01, 3'd3, -1, 1'b0);
      bdata[0] = 64'h0; bstrb[0] = 8'h0F;
      do_write(9'h005, 32'h0, 8'd0, 2'b01, 3'd3, -1, 1'b0);
      do_read(9'h006, 32'h0, 8'd0, 2'b01, 3'd3, 0);

      // FIXED burst: last beat wins, neighbour untouched.
      bdata[0] = 64'hAAAA_AAAA_AAAA_AAAA; bdata[1] = 64'hBBBB_BBBB_BBBB_BBBB;
      bdata[2] = 64'hCCCC_CCCC_CCCC_CCCC;
      for (int i = 0; i < 3; i++) bstrb[i] = 8'hFF;
      do_write(9'h007, 32'h80, 8'd2, 2'b00, 3'd3, -1, 1'b0);
      do_read(9'h008, 32'h80, 8'd1, 2'b01, 3'd3, 2);

      // Unsupported burst type on write: SLVERR, memory unchanged.
      for (int i = 0; i < 2; i++) begin bdata[i] = {$urandom, $urandom}; bstrb[i] = 8'hFF; end
      do_write(9'h009, 32'h80, 8'd1, 2'b10, 3'd3, -1, 1'b0);
      do_read(9'h00A, 32'h80, 8'd1, 2'b01, 3'd3, 0);

      // Unsupported size on read: SLVERR and zero data on every beat.
      do_read(9'h00B, 32'h80, 8'd2, 2'b01, 3'd2, 2);

      // Early w_last: all four beats taken, SLVERR reported.
      for (int i = 0; i < 4; i++) begin bdata[i] = {$urandom, $urandom}; bstrb[i] = 8'h00; end
      do_write(9'h00C, 32'h180, 8'd3, 2'b01, 3'd3, 1, 1'b0);

      // Reset after two of four W beats.
      for (int i = 0; i < 4; i++) begin bdata[i] = {$urandom, $urandom}; bstrb[i] = 8'hFF; end
      send_aw(9'h00D, 32'h140, 8'd3, 2'b01, 3'd3);
      for (int i = 0; i < 2; i++) begin
         s_if.w_data = bdata[i]; s_if.w_strb = bstrb[i]; s_if.w_last = 1'b0;
         s_if.w_valid = 1'b1;
         check("mid_w_ready", 64'(s_if.w_ready), 64'd1);
         step();
         model_write(word_of(32'h140, i, 2'b01), bdata[i], bstrb[i]);
      end
      s_if.w_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_aw_ready", 64'(s_if.aw_ready), 64'd1);
      check("mid_w_ready_clr", 64'(s_if.w_ready), 64'd0);
      s_if.b_ready = 1'b1;
      repeat (3) begin
         step();
         check("mid_no_b", 64'(s_if.b_valid), 64'd0);
      end
      s_if.b_ready = 1'b0;
      do_read(9'h00E, 32'h140, 8'd1, 2'b01, 3'd3, 0);

      // Address MEM_WORDS*8 aliases word 0.
      bdata[0] = {$urandom, $urandom}; bstrb[0] = 8'hFF;
      do_write(9'h00F, 32'(MW * 8), 8'd0, 2'b01, 3'd3, -1, 1'b0);
      do_read(9'h010, 32'h0, 8'd0, 2'b01, 3'd3, 0);
      // INCR read crossing the top of the array.
      do_read(9'h011, 32'(MW * 8 - 16), 8'd3, 2'b01, 3'd3, 2);

      // Same-edge write and read load of one word returns the old value.
      old_val = model[5];
      new_val = ~old_val;
      send_aw(9'h012, 32'h28, 8'd0, 2'b01, 3'd3);
      s_if.w_data = new_val; s_if.w_strb = 8'hFF; s_if.w_last = 1'b1; s_if.w_valid = 1'b1;
      s_if.ar_id = 9'h013; s_if.ar_addr = 32'h28; s_if.ar_len = 8'd0; s_if.ar_burst = 2'b01;
      s_if.ar_size = 3'd3; s_if.ar_valid = 1'b1;
      check("rbw_w_ready", 64'(s_if.w_ready), 64'd1);
      check("rbw_ar_ready", 64'(s_if.ar_ready), 64'd1);
      step();
      s_if.w_valid = 1'b0; s_if.w_last = 1'b0; s_if.ar_valid = 1'b0;
      check("rbw_r_valid", 64'(s_if.r_valid), 64'd1);
      check("rbw_old_data", s_if.r_data, old_val);
      check("rbw_b_valid", 64'(s_if.b_valid), 64'd1);
      s_if.r_ready = 1'b1; s_if.b_ready = 1'b1;
      step();
      s_if.r_ready = 1'b0; s_if.b_ready = 1'b0;
      model[5] = new_val;
      do_read(9'h014, 32'h28, 8'd0, 2'b01, 3'd3, 0);

      // Random bursts, each followed by a read-back with random back-pressure.
      for (int n = 0; n < 25; n++) begin
         ra = 32'($urandom_range(0, 2 * MW * 8 - 1));
         rl = 8'($urandom_range(0, 7));
         t  = $urandom_range(0, 9);
         rb = (t < 4) ? 2'b01 : (t < 8) ? 2'b00 : 2'(t - 6);
         rs = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd3;
         for (int i = 0; i <= int'(rl); i++) begin
            bdata[i] = {$urandom, $urandom};
            bstrb[i] = 8'($urandom);
         end
         do_write(9'($urandom), ra, rl, rb, rs, -1, 1'b1);
         do_read(9'($urandom), ra, rl, rb, rs, 2);
         do_read(9'($urandom), ra, rl, 2'b01, 3'd3, 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
